// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle bus of the decode stage.
// The master side is the fetch/execute environment around the stage; the
// slave side is the decode stage itself. Signal names keep the direction
// affixes as seen from the decode stage.
interface decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
);
    // Upstream (fetch) side
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      instr_i;
    logic [XLEN-1:0]  pc_i;

    // Downstream (execute) side
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  pc_o;
    logic [4:0]       rd_o;
    logic [4:0]       rs1_o;
    logic [4:0]       rs2_o;
    logic [2:0]       funct3_o;
    logic             funct7b5_o;
    logic [XLEN-1:0]  imm_o;
    logic             regwrite_o;
    logic             memread_o;
    logic             memwrite_o;
    logic             memtoreg_o;
    logic             alusrc_o;
    logic             branch_o;
    logic             jump_o;
    logic             ctrl_r_o;
    logic [2:0]       aluop_o;
    logic             jalr_o;
    logic             lui_o;
    logic             auipc_o;
    logic             illegal_o;
    logic [CNT_W-1:0] illegal_cnt_o;

    modport master (
        output flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_o, rd_o, rs1_o, rs2_o, funct3_o,
               funct7b5_o, imm_o, regwrite_o, memread_o, memwrite_o,
               memtoreg_o, alusrc_o, branch_o, jump_o, ctrl_r_o, aluop_o,
               jalr_o, lui_o, auipc_o, illegal_o, illegal_cnt_o
    );

    modport slave (
        input  flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_o, rd_o, rs1_o, rs2_o, funct3_o,
               funct7b5_o, imm_o, regwrite_o, memread_o, memwrite_o,
               memtoreg_o, alusrc_o, branch_o, jump_o, ctrl_r_o, aluop_o,
               jalr_o, lui_o, auipc_o, illegal_o, illegal_cnt_o
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: one instruction per cycle behind a
// valid/ready handshake, decoded into registered control, register indices
// and a sign-extended immediate. Unknown encodings are passed downstream
// flagged as illegal and counted in a saturating counter.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Saturating increment of the illegal-instruction counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Combinational decode of the presented instruction
    logic [6:0]      opcode_s;
    logic            regwrite_s, memread_s, memwrite_s, memtoreg_s;
    logic            alusrc_s, branch_s, jump_s, ctrl_r_s;
    logic [2:0]      aluop_s;
    logic            jalr_s, lui_s, auipc_s, illegal_s;
    logic [31:0]     imm32_s;
    logic [XLEN-1:0] imm_s;
    logic            accept_s;
    logic            in_ready_s;

    // Registered state and bundle
    state_t           state_r;
    logic [XLEN-1:0]  pc_r;
    logic [4:0]       rd_r, rs1_r, rs2_r;
    logic [2:0]       funct3_r;
    logic             funct7b5_r;
    logic [XLEN-1:0]  imm_r;
    logic             regwrite_r, memread_r, memwrite_r, memtoreg_r;
    logic             alusrc_r, branch_r, jump_r, ctrl_r_r;
    logic [2:0]       aluop_r;
    logic             jalr_r, lui_r, auipc_r, illegal_r;
    logic [CNT_W-1:0] illegal_cnt_r;

    assign opcode_s = bus.instr_i[6:0];

    // Main decoder: control class and immediate format per opcode. Every
    // legal opcode ends in 2'b11, so a non-11 low pair falls into default.
    always_comb begin
        regwrite_s = 1'b0;
        memread_s  = 1'b0;
        memwrite_s = 1'b0;
        memtoreg_s = 1'b0;
        alusrc_s   = 1'b0;
        branch_s   = 1'b0;
        jump_s     = 1'b0;
        ctrl_r_s   = 1'b0;
        aluop_s    = 3'b000;
        jalr_s     = 1'b0;
        lui_s      = 1'b0;
        auipc_s    = 1'b0;
        illegal_s  = 1'b0;
        imm32_s    = 32'h0000_0000;
        case (opcode_s)
            OP_R: begin
                regwrite_s = 1'b1;
                ctrl_r_s   = 1'b1;
                aluop_s    = 3'b001;
            end
            OP_I: begin
                regwrite_s = 1'b1;
                alusrc_s   = 1'b1;
                aluop_s    = 3'b010;
                imm32_s    = {{20{bus.instr_i[31]}}, bus.instr_i[31:20]};
            end
            OP_S: begin
                memwrite_s = 1'b1;
                alusrc_s   = 1'b1;
                aluop_s    = 3'b011;
                imm32_s    = {{20{bus.instr_i[31]}}, bus.instr_i[31:25], bus.instr_i[11:7]};
            end
            OP_L: begin
                regwrite_s = 1'b1;
                memread_s  = 1'b1;
                memtoreg_s = 1'b1;
                alusrc_s   = 1'b1;
                aluop_s    = 3'b100;
                imm32_s    = {{20{bus.instr_i[31]}}, bus.instr_i[31:20]};
            end
            OP_JAL: begin
                regwrite_s = 1'b1;
                jump_s     = 1'b1;
                aluop_s    = 3'b101;
                imm32_s    = {{11{bus.instr_i[31]}}, bus.instr_i[31], bus.instr_i[19:12],
                              bus.instr_i[20], bus.instr_i[30:21], 1'b0};
            end
            OP_JALR: begin
                regwrite_s = 1'b1;
                alusrc_s   = 1'b1;
                jump_s     = 1'b1;
                jalr_s     = 1'b1;
                aluop_s    = 3'b101;
                imm32_s    = {{20{bus.instr_i[31]}}, bus.instr_i[31:20]};
            end
            OP_B: begin
                branch_s   = 1'b1;
                aluop_s    = 3'b110;
                imm32_s    = {{19{bus.instr_i[31]}}, bus.instr_i[31], bus.instr_i[7],
                              bus.instr_i[30:25], bus.instr_i[11:8], 1'b0};
            end
            OP_LUI: begin
                regwrite_s = 1'b1;
                alusrc_s   = 1'b1;
                lui_s      = 1'b1;
                aluop_s    = 3'b111;
                imm32_s    = {bus.instr_i[31:12], 12'h000};
            end
            OP_AUIPC: begin
                regwrite_s = 1'b1;
                alusrc_s   = 1'b1;
                auipc_s    = 1'b1;
                aluop_s    = 3'b111;
                imm32_s    = {bus.instr_i[31:12], 12'h000};
            end
            default: begin
                illegal_s  = 1'b1;
            end
        endcase
    end

    // Widen the 32-bit immediate to XLEN by sign extension
    assign imm_s = XLEN'($signed(imm32_s));

    assign in_ready_s = (state_r == ST_EMPTY) || bus.out_ready_i;
    assign accept_s   = bus.in_valid_i && in_ready_s && !bus.flush_i;

    // Stage FSM and bundle registers: flush beats accept beats drain/hold
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r       <= ST_EMPTY;
            pc_r          <= {XLEN{1'b0}};
            rd_r          <= 5'd0;
            rs1_r         <= 5'd0;
            rs2_r         <= 5'd0;
            funct3_r      <= 3'd0;
            funct7b5_r    <= 1'b0;
            imm_r         <= {XLEN{1'b0}};
            regwrite_r    <= 1'b0;
            memread_r     <= 1'b0;
            memwrite_r    <= 1'b0;
            memtoreg_r    <= 1'b0;
            alusrc_r      <= 1'b0;
            branch_r      <= 1'b0;
            jump_r        <= 1'b0;
            ctrl_r_r      <= 1'b0;
            aluop_r       <= 3'd0;
            jalr_r        <= 1'b0;
            lui_r         <= 1'b0;
            auipc_r       <= 1'b0;
            illegal_r     <= 1'b0;
            illegal_cnt_r <= {CNT_W{1'b0}};
        end else if (bus.flush_i) begin
            state_r <= ST_EMPTY;
        end else if (accept_s) begin
            state_r    <= ST_FULL;
            pc_r       <= bus.pc_i;
            rd_r       <= bus.instr_i[11:7];
            rs1_r      <= bus.instr_i[19:15];
            rs2_r      <= bus.instr_i[24:20];
            funct3_r   <= bus.instr_i[14:12];
            funct7b5_r <= bus.instr_i[30];
            imm_r      <= imm_s;
            regwrite_r <= regwrite_s;
            memread_r  <= memread_s;
            memwrite_r <= memwrite_s;
            memtoreg_r <= memtoreg_s;
            alusrc_r   <= alusrc_s;
            branch_r   <= branch_s;
            jump_r     <= jump_s;
            ctrl_r_r   <= ctrl_r_s;
            aluop_r    <= aluop_s;
            jalr_r     <= jalr_s;
            lui_r      <= lui_s;
            auipc_r    <= auipc_s;
            illegal_r  <= illegal_s;
            if (illegal_s) begin
                illegal_cnt_r <= sat_inc(illegal_cnt_r);
            end else begin
                illegal_cnt_r <= illegal_cnt_r;
            end
        end else begin
            case (state_r)
                ST_FULL: begin
                    if (bus.out_ready_i) begin
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready_o    = in_ready_s;
    assign bus.out_valid_o   = (state_r == ST_FULL);
    assign bus.pc_o          = pc_r;
    assign bus.rd_o          = rd_r;
    assign bus.rs1_o         = rs1_r;
    assign bus.rs2_o         = rs2_r;
    assign bus.funct3_o      = funct3_r;
    assign bus.funct7b5_o    = funct7b5_r;
    assign bus.imm_o         = imm_r;
    assign bus.regwrite_o    = regwrite_r;
    assign bus.memread_o     = memread_r;
    assign bus.memwrite_o    = memwrite_r;
    assign bus.memtoreg_o    = memtoreg_r;
    assign bus.alusrc_o      = alusrc_r;
    assign bus.branch_o      = branch_r;
    assign bus.jump_o        = jump_r;
    assign bus.ctrl_r_o      = ctrl_r_r;
    assign bus.aluop_o       = aluop_r;
    assign bus.jalr_o        = jalr_r;
    assign bus.lui_o         = lui_r;
    assign bus.auipc_o       = auipc_r;
    assign bus.illegal_o     = illegal_r;
    assign bus.illegal_cnt_o = illegal_cnt_r;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a directed decode table, hand-written handshake
// corner sequences and a randomized run, all checked against a behavioural
// model. A second instance with a 2-bit counter shares the stimulus so that
// counter saturation is exercised quickly.
module tb_decode_stage;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc = 32'h0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(XLEN), .CNT_W(8)) bus ();
    decode_stage_if #(.XLEN(XLEN), .CNT_W(2)) bus2 ();

    assign bus.flush_i     = flush;
    assign bus.in_valid_i  = in_valid;
    assign bus.instr_i     = instr;
    assign bus.pc_i        = pc;
    assign bus.out_ready_i = out_ready;
    assign bus2.flush_i     = flush;
    assign bus2.in_valid_i  = in_valid;
    assign bus2.instr_i     = instr;
    assign bus2.pc_i        = pc;
    assign bus2.out_ready_i = out_ready;

    decode_stage #(.XLEN(XLEN), .CNT_W(8)) dut  (.clk_i(clk), .rst_i(rst), .bus(bus));
    decode_stage #(.XLEN(XLEN), .CNT_W(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

    // ctrl = {regwrite,memread,memwrite,memtoreg,alusrc,branch,jump,ctrl_r}
    // flags = {jalr,lui,auipc,illegal}
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [31:0] imm;
        logic [7:0]  ctrl;
        logic [2:0]  aluop;
        logic [3:0]  flags;
    } bundle_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [7:0]  ctrl;
        logic [2:0]  aluop;
        logic [3:0]  flags;
        logic [31:0] imm;
    } vec_t;

    bundle_t act_b, act_b2;
    always_comb act_b = {bus.pc_o, bus.rd_o, bus.rs1_o, bus.rs2_o, bus.funct3_o, bus.funct7b5_o,
                         bus.imm_o, bus.regwrite_o, bus.memread_o, bus.memwrite_o, bus.memtoreg_o,
                         bus.alusrc_o, bus.branch_o, bus.jump_o, bus.ctrl_r_o, bus.aluop_o,
                         bus.jalr_o, bus.lui_o, bus.auipc_o, bus.illegal_o};
    always_comb act_b2 = {bus2.pc_o, bus2.rd_o, bus2.rs1_o, bus2.rs2_o, bus2.funct3_o, bus2.funct7b5_o,
                          bus2.imm_o, bus2.regwrite_o, bus2.memread_o, bus2.memwrite_o, bus2.memtoreg_o,
                          bus2.alusrc_o, bus2.branch_o, bus2.jump_o, bus2.ctrl_r_o, bus2.aluop_o,
                          bus2.jalr_o, bus2.lui_o, bus2.auipc_o, bus2.illegal_o};

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: one held bundle plus the two counters
    bundle_t     m_b;
    logic        m_v;
    int unsigned m_cnt8;
    int unsigned m_cnt2;

    // Decode written from the ISA field definitions with arithmetic shifts
    function automatic bundle_t decode_ref(input logic [31:0] ins, input logic [31:0] a);
        bundle_t b;
        int      s;
        b      = '0;
        b.pc   = a;
        b.rd   = ins[11:7];
        b.rs1  = ins[19:15];
        b.rs2  = ins[24:20];
        b.f3   = ins[14:12];
        b.f7b5 = ins[30];
        s      = $signed(ins) >>> 31;
        case (ins[6:0])
            7'b0110011: begin b.ctrl = 8'b1000_0001; b.aluop = 3'd1; end
            7'b0010011: begin b.ctrl = 8'b1000_1000; b.aluop = 3'd2; b.imm = 32'($signed(ins) >>> 20); end
            7'b0100011: begin
                b.ctrl = 8'b0010_1000; b.aluop = 3'd3;
                b.imm  = 32'(s <<< 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
            end
            7'b0000011: begin b.ctrl = 8'b1101_1000; b.aluop = 3'd4; b.imm = 32'($signed(ins) >>> 20); end
            7'b1101111: begin
                b.ctrl = 8'b1000_0010; b.aluop = 3'd5;
                b.imm  = 32'(s <<< 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            end
            7'b1100111: begin
                b.ctrl = 8'b1000_1010; b.aluop = 3'd5; b.flags = 4'b1000;
                b.imm  = 32'($signed(ins) >>> 20);
            end
            7'b1100011: begin
                b.ctrl = 8'b0000_0100; b.aluop = 3'd6;
                b.imm  = 32'(s <<< 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            end
            7'b0110111: begin b.ctrl = 8'b1000_1000; b.aluop = 3'd7; b.flags = 4'b0100; b.imm = ins & 32'hFFFF_F000; end
            7'b0010111: begin b.ctrl = 8'b1000_1000; b.aluop = 3'd7; b.flags = 4'b0010; b.imm = ins & 32'hFFFF_F000; end
            default:    begin b.flags = 4'b0001; end
        endcase
        return b;
    endfunction

    task automatic model_reset();
        m_v    = 1'b0;
        m_b    = '0;
        m_cnt8 = 0;
        m_cnt2 = 0;
    endtask

    task automatic model_update();
        if (flush) begin
            m_v = 1'b0;
        end else if (in_valid && (!m_v || out_ready)) begin
            m_b = decode_ref(instr, pc);
            m_v = 1'b1;
            if (m_b.flags[0]) begin
                if (m_cnt8 < 255) m_cnt8 = m_cnt8 + 1;
                if (m_cnt2 < 3)   m_cnt2 = m_cnt2 + 1;
            end
        end else if (out_ready) begin
            m_v = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic with_bundle);
        chk({name, "/valid"},  128'(bus.out_valid_o),   128'(m_v));
        chk({name, "/valid2"}, 128'(bus2.out_valid_o),  128'(m_v));
        chk({name, "/cnt8"},   128'(bus.illegal_cnt_o), 128'(m_cnt8));
        chk({name, "/cnt2"},   128'(bus2.illegal_cnt_o), 128'(m_cnt2));
        if (m_v || with_bundle) begin
            chk({name, "/bundle"},  128'(act_b),  128'(m_b));
            chk({name, "/bundle2"}, 128'(act_b2), 128'(m_b));
        end
    endtask

    // One clock: check in_ready for the driven inputs, clock, check outputs
    task automatic step(input string name);
        #1;
        chk({name, "/in_ready"},  128'(bus.in_ready_o),  128'(!m_v || out_ready));
        chk({name, "/in_ready2"}, 128'(bus2.in_ready_o), 128'(!m_v || out_ready));
        @(posedge clk);
        model_update();
        #1;
        check_state(name, 1'b0);
    endtask

    vec_t       vecs [12];
    logic [6:0] ops [9];

    initial begin
        logic [31:0] r;
        int          sel;

        vecs[0]  = '{32'h0050_0093, 32'h100, 8'b1000_1000, 3'b010, 4'b0000, 32'h0000_0005};
        vecs[1]  = '{32'hFE20_AE23, 32'h104, 8'b0010_1000, 3'b011, 4'b0000, 32'hFFFF_FFFC};
        vecs[2]  = '{32'h0080_00EF, 32'h108, 8'b1000_0010, 3'b101, 4'b0000, 32'h0000_0008};
        vecs[3]  = '{32'h0000_0000, 32'h10C, 8'b0000_0000, 3'b000, 4'b0001, 32'h0000_0000};
        vecs[4]  = '{32'h1234_50B7, 32'h110, 8'b1000_1000, 3'b111, 4'b0100, 32'h1234_5000};
        vecs[5]  = '{32'hFFFF_F117, 32'h114, 8'b1000_1000, 3'b111, 4'b0010, 32'hFFFF_F000};
        vecs[6]  = '{32'hFFC0_8067, 32'h118, 8'b1000_1010, 3'b101, 4'b1000, 32'hFFFF_FFFC};
        vecs[7]  = '{32'hFE00_0EE3, 32'h11C, 8'b0000_0100, 3'b110, 4'b0000, 32'hFFFF_FFFC};
        vecs[8]  = '{32'h0080_A103, 32'h120, 8'b1101_1000, 3'b100, 4'b0000, 32'h0000_0008};
        vecs[9]  = '{32'h4020_8033, 32'h124, 8'b1000_0001, 3'b001, 4'b0000, 32'h0000_0000};
        vecs[10] = '{32'h0050_0091, 32'h128, 8'b0000_0000, 3'b000, 4'b0001, 32'h0000_0000};
        vecs[11] = '{32'h0000_007F, 32'h12C, 8'b0000_0000, 3'b000, 4'b0001, 32'h0000_0000};
        ops = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011, 7'b1101111,
                7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 1'b1);
        chk("reset/in_ready", 128'(bus.in_ready_o), 128'(1'b1));
        rst = 1'b0;

        // Decode table, back to back at full throughput
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            instr    = vecs[i].instr;
            pc       = vecs[i].pc;
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d/ctrl", i),  128'(act_b.ctrl),  128'(vecs[i].ctrl));
            chk($sformatf("vec%0d/aluop", i), 128'(act_b.aluop), 128'(vecs[i].aluop));
            chk($sformatf("vec%0d/flags", i), 128'(act_b.flags), 128'(vecs[i].flags));
            chk($sformatf("vec%0d/imm", i),   128'(act_b.imm),   128'(vecs[i].imm));
            chk($sformatf("vec%0d/pc", i),    128'(act_b.pc),    128'(vecs[i].pc));
        end
        in_valid = 1'b0;
        step("drain");

        // Five illegal words: the 2-bit counter must stick at 3
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            instr    = 32'h0000_0000;
            pc       = 32'h180 + 32'(k * 4);
            step("sat");
        end
        chk("sat/cnt2_max", 128'(bus2.illegal_cnt_o), 128'(2'd3));
        in_valid = 1'b0;
        step("sat_drain");

        // Backpressure: hold three cycles with a pending instruction
        in_valid  = 1'b1;
        instr     = 32'h0050_0093;
        pc        = 32'h200;
        out_ready = 1'b1;
        step("bp_load");
        instr     = 32'h1234_50B7;
        pc        = 32'h204;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("bp_stall");
            chk("bp_stall/in_ready_low", 128'(bus.in_ready_o), 128'(1'b0));
            chk("bp_stall/pc_held", 128'(bus.pc_o), 128'(32'h200));
        end
        out_ready = 1'b1;
        step("bp_release");
        chk("bp_release/pc", 128'(bus.pc_o), 128'(32'h204));
        in_valid = 1'b0;
        step("bp_drain");
        chk("bp_drain/empty", 128'(bus.out_valid_o), 128'(1'b0));

        // Flush while FULL with an illegal word presented
        in_valid = 1'b1;
        instr    = 32'h0050_0093;
        pc       = 32'h300;
        step("fl_load");
        flush    = 1'b1;
        instr    = 32'h0000_0000;
        pc       = 32'h304;
        step("flush");
        flush    = 1'b0;
        in_valid = 1'b0;
        step("fl_after");

        // Asynchronous reset while FULL and stalled
        in_valid = 1'b1;
        instr    = 32'h0000_0000;
        pc       = 32'h400;
        step("ar_load");
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step("ar_stall");
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_state("async_rst", 1'b1);
        chk("async_rst/valid0", 128'(bus.out_valid_o), 128'(1'b0));
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        step("ar_after");

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r         = $urandom();
            sel       = int'($urandom_range(0, 9));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            instr     = (sel < 9) ? {r[31:7], ops[sel]} : r;
            pc        = $urandom() & 32'hFFFF_FFFC;
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
